// File: rtl/ranger_pkg.sv
// Shared state encoding, default timing constants and counter sizing helper
// for the ultrasonic ranger.
package ranger_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_ECHO = 3'd2,
    MEASURE   = 3'd3,
    HOLD      = 3'd4
  } state_e;

  localparam logic [2:0] ST_IDLE      = IDLE;
  localparam logic [2:0] ST_TRIG      = TRIG;
  localparam logic [2:0] ST_WAIT_ECHO = WAIT_ECHO;
  localparam logic [2:0] ST_MEASURE   = MEASURE;
  localparam logic [2:0] ST_HOLD      = HOLD;

  localparam int DEF_TRIG_CYCLES      = 500;
  localparam int DEF_CYCLES_PER_CM    = 2900;
  localparam int DEF_ECHO_WAIT_CYCLES = 1500000;
  localparam int DEF_PERIOD_CYCLES    = 3000000;
  localparam int DEF_MAX_CM           = 400;

  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ultrasonic_ranger_if.sv
// Sensor pins plus the distance result bundle; slave is the ranger side,
// master is whoever drives enable/echo and consumes the distance.
interface ultrasonic_ranger_if;
  logic        en;
  logic        echo;
  logic        trig;
  logic [15:0] distance;
  logic        distance_valid;
  logic        timeout;

  modport master (
    output en, echo,
    input  trig, distance, distance_valid, timeout
  );

  modport slave (
    input  en, echo,
    output trig, distance, distance_valid, timeout
  );
endinterface

// File: rtl/ultrasonic_ranger_median3.sv
// Median of three 16-bit values, registered when i_load is high and held
// otherwise.
module median3 (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic [15:0] i_c,
  output logic [15:0] o_med
);
  logic [15:0] w_lo;
  logic [15:0] w_hi;
  logic [15:0] w_mid;
  logic [15:0] r_med;

  always_comb begin
    w_lo  = (i_a < i_b) ? i_a : i_b;
    w_hi  = (i_a < i_b) ? i_b : i_a;
    w_mid = (i_c < w_hi) ? i_c : w_hi;
    w_mid = (w_mid > w_lo) ? w_mid : w_lo;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_med <= '0;
    end else if (i_load) begin
      r_med <= w_mid;
    end
  end

  assign o_med = r_med;
endmodule

// File: rtl/ultrasonic_ranger.sv
// HC-SR04 style ranger: periodic trigger, echo width to cm via prescaler.
// Optional RANGER_MEDIAN3_EN: publish median of the last three results.
module ultrasonic_ranger
  import ranger_pkg::*;
#(
  parameter int TRIG_CYCLES      = DEF_TRIG_CYCLES,
  parameter int CYCLES_PER_CM    = DEF_CYCLES_PER_CM,
  parameter int ECHO_WAIT_CYCLES = DEF_ECHO_WAIT_CYCLES,
  parameter int PERIOD_CYCLES    = DEF_PERIOD_CYCLES,
  parameter int MAX_CM           = DEF_MAX_CM
) (
  input logic               clk,
  input logic               rst,
  ultrasonic_ranger_if.slave bus
);
  localparam int PHW = cnt_width(((TRIG_CYCLES > ECHO_WAIT_CYCLES) ? TRIG_CYCLES : ECHO_WAIT_CYCLES) + 1);
  localparam int PSW = cnt_width(CYCLES_PER_CM);
  localparam int CMW = cnt_width(MAX_CM + 1);
  localparam int PDW = cnt_width(PERIOD_CYCLES);

  localparam logic [PHW-1:0] TRIG_LAST  = PHW'(TRIG_CYCLES - 1);
  localparam logic [PHW-1:0] WAIT_LAST  = PHW'(ECHO_WAIT_CYCLES - 1);
  localparam logic [PSW-1:0] PRESC_LAST = PSW'(CYCLES_PER_CM - 1);
  localparam logic [CMW-1:0] CM_MAX     = CMW'(MAX_CM);
  localparam logic [PDW-1:0] PERIOD_SAT = PDW'(PERIOD_CYCLES - 1);
  // Leaving HOLD one count early lets IDLE fire the next trigger exactly on the period.
  localparam logic [PDW-1:0] HOLD_EXIT  = PDW'((PERIOD_CYCLES > 1) ? PERIOD_CYCLES - 2 : 0);

  logic           r_echo_meta, r_echo_s, r_echo_d;
  logic [2:0]     r_state;
  logic [PHW-1:0] r_phase;
  logic [PSW-1:0] r_presc;
  logic [CMW-1:0] r_cm;
  logic [PDW-1:0] r_period;
  logic           r_trig;

  logic           w_rise, w_fall, w_wrap;
  logic [PSW-1:0] w_presc_base, w_presc_step;
  logic [CMW-1:0] w_cm_base, w_cm_step;
  logic           w_done, w_res_to;
  logic [15:0]    w_res_cm;

  assign w_rise = r_echo_s & ~r_echo_d;
  assign w_fall = ~r_echo_s & r_echo_d;

  // The rising-edge cycle is itself a high cycle, so it is counted on entry to MEASURE.
  always_comb begin
    w_presc_base = (r_state == ST_MEASURE) ? r_presc : '0;
    w_cm_base    = (r_state == ST_MEASURE) ? r_cm : '0;
    w_wrap       = (w_presc_base == PRESC_LAST);
    w_presc_step = w_wrap ? '0 : w_presc_base + PSW'(1);
    w_cm_step    = (w_wrap && (w_cm_base != CM_MAX)) ? w_cm_base + CMW'(1) : w_cm_base;
  end

  always_comb begin
    w_done   = 1'b0;
    w_res_cm = '0;
    w_res_to = 1'b0;
    if (r_state == ST_WAIT_ECHO && !w_rise && r_phase == WAIT_LAST) begin
      w_done   = 1'b1;
      w_res_cm = 16'(MAX_CM);
      w_res_to = 1'b1;
    end else if (r_state == ST_MEASURE) begin
      if (w_fall) begin
        w_done   = 1'b1;
        w_res_cm = 16'(r_cm);
      end else if (r_phase == WAIT_LAST) begin
        w_done   = 1'b1;
        w_res_cm = 16'(MAX_CM);
        w_res_to = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_echo_meta <= 1'b0;
      r_echo_s    <= 1'b0;
      r_echo_d    <= 1'b0;
      r_state     <= ST_IDLE;
      r_phase     <= '0;
      r_presc     <= '0;
      r_cm        <= '0;
      r_period    <= '0;
      r_trig      <= 1'b0;
    end else begin
      r_echo_meta <= bus.echo;
      r_echo_s    <= r_echo_meta;
      r_echo_d    <= r_echo_s;

      if (r_state == ST_IDLE)
        r_period <= '0;
      else if (r_period != PERIOD_SAT)
        r_period <= r_period + PDW'(1);

      case (r_state)
        ST_IDLE: begin
          if (bus.en) begin
            r_state <= ST_TRIG;
            r_trig  <= 1'b1;
            r_phase <= '0;
          end
        end
        ST_TRIG: begin
          if (r_phase == TRIG_LAST) begin
            r_trig  <= 1'b0;
            r_state <= ST_WAIT_ECHO;
            r_phase <= '0;
          end else begin
            r_phase <= r_phase + PHW'(1);
          end
        end
        ST_WAIT_ECHO: begin
          if (w_rise) begin
            r_state <= ST_MEASURE;
            r_presc <= w_presc_step;
            r_cm    <= w_cm_step;
            r_phase <= PHW'(1);
          end else if (w_done) begin
            r_state <= ST_HOLD;
          end else begin
            r_phase <= r_phase + PHW'(1);
          end
        end
        ST_MEASURE: begin
          if (w_done) begin
            r_state <= ST_HOLD;
          end else begin
            r_presc <= w_presc_step;
            r_cm    <= w_cm_step;
            r_phase <= r_phase + PHW'(1);
          end
        end
        ST_HOLD: begin
          if (r_period >= HOLD_EXIT)
            r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef RANGER_MEDIAN3_EN
  logic [15:0] r_hist0, r_hist1, r_hist2;
  logic        r_primed, r_stage_valid, r_stage_to, r_valid, r_to;
  logic [15:0] w_med;

  // History advances on the same edge the raw result is decided.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hist0       <= '0;
      r_hist1       <= '0;
      r_hist2       <= '0;
      r_primed      <= 1'b0;
      r_stage_valid <= 1'b0;
      r_stage_to    <= 1'b0;
      r_valid       <= 1'b0;
      r_to          <= 1'b0;
    end else begin
      r_stage_valid <= w_done;
      r_valid       <= r_stage_valid;
      if (w_done) begin
        r_stage_to <= w_res_to;
        r_primed   <= 1'b1;
        r_hist0    <= w_res_cm;
        r_hist1    <= r_primed ? r_hist0 : w_res_cm;
        r_hist2    <= r_primed ? r_hist1 : w_res_cm;
      end
      if (r_stage_valid)
        r_to <= r_stage_to;
    end
  end

  median3 u_median3 (
    .clk    (clk),
    .rst    (rst),
    .i_load (r_stage_valid),
    .i_a    (r_hist0),
    .i_b    (r_hist1),
    .i_c    (r_hist2),
    .o_med  (w_med)
  );

  assign bus.distance       = w_med;
  assign bus.distance_valid = r_valid;
  assign bus.timeout        = r_to;
`else
  logic [15:0] r_dist;
  logic        r_valid, r_to;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dist  <= '0;
      r_valid <= 1'b0;
      r_to    <= 1'b0;
    end else begin
      r_valid <= w_done;
      if (w_done) begin
        r_dist <= w_res_cm;
        r_to   <= w_res_to;
      end
    end
  end

  assign bus.distance       = r_dist;
  assign bus.distance_valid = r_valid;
  assign bus.timeout        = r_to;
`endif

  assign bus.trig = r_trig;
endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed bench for ultrasonic_ranger with small timing parameters;
// expectations follow RANGER_MEDIAN3_EN when it is defined.
module tb_ultrasonic_ranger;
  localparam int TRIG   = 10;
  localparam int CPC    = 58;
  localparam int WAITC  = 2000;
  localparam int PERIOD = 5000;
  localparam int MAXCM  = 20;
`ifdef RANGER_MEDIAN3_EN
  localparam int MED = 1;
`else
  localparam int MED = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ultrasonic_ranger_if bus ();

  ultrasonic_ranger #(
    .TRIG_CYCLES      (TRIG),
    .CYCLES_PER_CM    (CPC),
    .ECHO_WAIT_CYCLES (WAITC),
    .PERIOD_CYCLES    (PERIOD),
    .MAX_CM           (MAXCM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int last_rise = 0;

  // width 0 means no echo at all; exp_med is the filtered value with the median option.
  typedef struct {
    int delay;
    int width;
    int exp_raw;
    int exp_med;
    bit exp_to;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_trig(input string tag, input bit chk_period, output int fall_cyc);
    int rise_cyc;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 6000 && !seen; i++) begin
      @(negedge clk);
      if (bus.trig === 1'b1) seen = 1'b1;
    end
    check({tag, " trig rise seen"}, int'(seen), 1);
    rise_cyc = cyc;
    if (chk_period) check({tag, " trig period"}, rise_cyc - last_rise, PERIOD);
    last_rise = rise_cyc;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus.trig === 1'b0) seen = 1'b1;
    end
    check({tag, " trig width"}, cyc - rise_cyc, TRIG);
    fall_cyc = cyc;
  endtask

  task automatic wait_result(input string tag, input int exp_cyc, input int exp_d, input bit exp_to);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (bus.distance_valid === 1'b1) seen = 1'b1;
    end
    check({tag, " valid seen"}, int'(seen), 1);
    check({tag, " valid cycle"}, cyc, exp_cyc);
    check({tag, " distance"}, int'(bus.distance), exp_d);
    check({tag, " timeout"}, int'(bus.timeout), int'(exp_to));
    $display("txn %s: distance=%0d timeout=%0d cycle=%0d", tag, bus.distance, bus.timeout, cyc);
    @(negedge clk);
    check({tag, " valid one cycle"}, int'(bus.distance_valid), 0);
  endtask

  task automatic run_vec(input string tag, input vec_t v, input bit chk_period);
    int fall_cyc;
    int k;
    int exp_cyc;
    wait_trig(tag, chk_period, fall_cyc);
    if (v.width > 0) begin
      repeat (v.delay) @(negedge clk);
      bus.echo = 1'b1;
      k = cyc;
      repeat (v.width) @(negedge clk);
      bus.echo = 1'b0;
      exp_cyc = k + v.width + 3 + MED;
    end else begin
      exp_cyc = fall_cyc + WAITC + MED;
    end
    wait_result(tag, exp_cyc, (MED != 0) ? v.exp_med : v.exp_raw, v.exp_to);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int f;
    int k;

    vecs[0] = '{100,  580, 10, 10, 1'b0};
    vecs[1] = '{100,   57,  0, 10, 1'b0};
    vecs[2] = '{100, 1159, 19, 10, 1'b0};
    vecs[3] = '{100,    0, 20, 19, 1'b1};
    vecs[4] = '{100,  580, 10, 10, 1'b0};
    vecs[5] = '{100,  290,  5, 10, 1'b0};
    vecs[6] = '{100,  696, 12, 10, 1'b0};
    vecs[7] = '{100,  174,  3,  5, 1'b0};

    rst = 1'b1;
    bus.en = 1'b0;
    bus.echo = 1'b0;
    repeat (3) @(negedge clk);
    check("reset trig", int'(bus.trig), 0);
    check("reset distance", int'(bus.distance), 0);
    check("reset valid", int'(bus.distance_valid), 0);
    check("reset timeout", int'(bus.timeout), 0);
    rst = 1'b0;
    bus.en = 1'b1;

    for (int i = 0; i < 4; i++)
      run_vec($sformatf("vec%0d", i), vecs[i], i != 0);

    // Echo rises and never falls: echo-high limit, then no-rise limit next period.
    wait_trig("stuck_high", 1'b1, f);
    repeat (100) @(negedge clk);
    bus.echo = 1'b1;
    k = cyc;
    wait_result("stuck_high", k + WAITC + 2 + MED, MAXCM, 1'b1);
    wait_trig("stuck_entry", 1'b1, f);
    wait_result("stuck_entry", f + WAITC + MED, MAXCM, 1'b1);
    bus.echo = 1'b0;

    // Reset in the middle of MEASURE.
    wait_trig("mid_reset", 1'b1, f);
    repeat (100) @(negedge clk);
    bus.echo = 1'b1;
    repeat (200) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_reset trig", int'(bus.trig), 0);
    check("mid_reset distance", int'(bus.distance), 0);
    check("mid_reset valid", int'(bus.distance_valid), 0);
    check("mid_reset timeout", int'(bus.timeout), 0);
    bus.echo = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 4; i < 8; i++)
      run_vec($sformatf("vec%0d", i), vecs[i], i != 4);

    bus.en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
